// File: rtl/pll_ext_pkg.sv
// rtl/pll_ext_pkg.sv - shared types and constants for the external-PLL DAC path
package pll_ext_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  localparam int          DAC8411_FRAME_CYCLES = 26;
  localparam logic [15:0] DAC_MIDSCALE         = 16'h8000;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running divider, one-cycle tick every DIV clocks
module tick_divider #(
  parameter int DIV = 26
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int              CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == '0);

  always_comb begin
    cnt_d = tick ? RELOAD : cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_slew_ramp.sv
// rtl/dac_slew_ramp.sv - slews the held DAC code toward an accepted target, one bounded step per tick
module dac_slew_ramp
  import pll_ext_pkg::*;
#(
  parameter int                   DAC_WIDTH  = 16,
  parameter int                   STEP_WIDTH = 16,
  parameter int                   UPDATE_DIV = DAC8411_FRAME_CYCLES,
  parameter logic [DAC_WIDTH-1:0] RESET_CODE = DAC_MIDSCALE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DAC_WIDTH-1:0]  target_code,
  input  logic                  target_valid,
  output logic                  target_ready,
  input  logic [STEP_WIDTH-1:0] step_size,
  input  logic                  ramp_enable,
  output logic [DAC_WIDTH-1:0]  dac_code,
  output logic                  update_strobe,
  output logic                  busy,
  output logic                  at_target
);

  ramp_state_t          state_q, state_d;
  logic [DAC_WIDTH-1:0] dac_q, dac_d;
  logic [DAC_WIDTH-1:0] tgt_q, tgt_d;
  logic [DAC_WIDTH-1:0] step_q, step_d;
  logic                 strobe_q, strobe_d;
  logic                 at_q, at_d;
  logic [DAC_WIDTH-1:0] step_in;
  logic [DAC_WIDTH:0]   diff;
  logic                 accept;
  logic                 tick;

  tick_divider #(
    .DIV (UPDATE_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign target_ready  = ~rst & (state_q == IDLE);
  assign busy          = (state_q == RAMP);
  assign accept        = target_valid & target_ready;
  assign step_in       = DAC_WIDTH'(step_size);
  assign dac_code      = dac_q;
  assign update_strobe = strobe_q;
  assign at_target     = at_q;

  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    tgt_d   = tgt_q;
    step_d  = step_q;

    // One extra bit so the distance is exact across the full code range.
    if (tgt_q >= dac_q) begin
      diff = {1'b0, tgt_q} - {1'b0, dac_q};
    end else begin
      diff = {1'b0, dac_q} - {1'b0, tgt_q};
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d  = target_code;
          step_d = (step_in == '0) ? DAC_WIDTH'(1) : step_in;
          if (!ramp_enable) begin
            dac_d = target_code;
          end else if (target_code != dac_q) begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (tick) begin
          if (diff <= {1'b0, step_q}) begin
            dac_d   = tgt_q;
            state_d = IDLE;
          end else if (tgt_q > dac_q) begin
            dac_d = dac_q + step_q;
          end else begin
            dac_d = dac_q - step_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    strobe_d = (dac_d != dac_q);
    at_d     = (dac_d == tgt_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dac_q    <= RESET_CODE;
      tgt_q    <= RESET_CODE;
      step_q   <= DAC_WIDTH'(1);
      strobe_q <= 1'b0;
      at_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      dac_q    <= dac_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      strobe_q <= strobe_d;
      at_q     <= at_d;
    end
  end

endmodule

// File: tb/tb_dac_slew_ramp.sv
// tb/tb_dac_slew_ramp.sv - randomized self-checking bench for dac_slew_ramp
module tb_dac_slew_ramp;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] target_code = 16'h0;
  logic        target_valid = 1'b0;
  logic        target_ready;
  logic [15:0] step_size = 16'h0;
  logic        ramp_enable = 1'b0;
  logic [15:0] dac_code;
  logic        update_strobe;
  logic        busy;
  logic        at_target;

  int ntests = 0;
  int nfail  = 0;
  int edge_cnt = 0;
  int mdl_code = 32'h8000;

  dac_slew_ramp #(
    .DAC_WIDTH  (16),
    .STEP_WIDTH (16),
    .UPDATE_DIV (DIV),
    .RESET_CODE (16'h8000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .target_code   (target_code),
    .target_valid  (target_valid),
    .target_ready  (target_ready),
    .step_size     (step_size),
    .ramp_enable   (ramp_enable),
    .dac_code      (dac_code),
    .update_strobe (update_strobe),
    .busy          (busy),
    .at_target     (at_target)
  );

  always #5 clk = ~clk;

  // Edge index since reset release; ticks land on edges that are multiples of DIV.
  always @(posedge clk) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ramp(input int tgt, input int stp, input bit en, input string name);
    int exp_v[$];
    int exp_e[$];
    int obs_v[$];
    int obs_e[$];
    int cur, s, t, ka, start, budget, strobe_bad;
    logic [15:0] prev;
    logic changed;
    start = mdl_code;
    target_code  = 16'(tgt);
    step_size    = 16'(stp);
    ramp_enable  = en;
    target_valid = 1'b1;
    ntests++;
    if (target_ready !== 1'b1) begin
      nfail++;
      $display("FAIL %s ready_before_accept got=%b want=1", name, target_ready);
    end
    step_cycle();
    target_valid = 1'b0;
    ka = edge_cnt;

    s   = (stp == 0) ? 1 : stp;
    cur = start;
    if (!en) begin
      if (tgt != cur) begin
        exp_v.push_back(tgt);
        exp_e.push_back(ka);
      end
    end else begin
      t = ((ka / DIV) + 1) * DIV;
      while (cur != tgt) begin
        if (((tgt > cur) ? tgt - cur : cur - tgt) <= s) cur = tgt;
        else if (tgt > cur) cur = cur + s;
        else cur = cur - s;
        exp_v.push_back(cur);
        exp_e.push_back(t);
        t += DIV;
      end
    end
    mdl_code = tgt;

    if (en && tgt != start) begin
      ntests++;
      if (busy !== 1'b1 || at_target !== 1'b0 || target_ready !== 1'b0) begin
        nfail++;
        $display("FAIL %s ramp_start busy=%b at=%b ready=%b want busy=1 at=0 ready=0",
                 name, busy, at_target, target_ready);
      end
    end

    prev = 16'(start);
    strobe_bad = 0;
    budget = exp_v.size() * DIV + 6;
    for (int c = 0; c < budget; c++) begin
      changed = (dac_code !== prev);
      if (update_strobe !== changed) strobe_bad++;
      if (changed) begin
        obs_v.push_back(int'(dac_code));
        obs_e.push_back(edge_cnt);
        prev = dac_code;
      end
      if (c != budget - 1) step_cycle();
    end

    ntests++;
    if (obs_v.size() != exp_v.size()) begin
      nfail++;
      $display("FAIL %s change_count got=%0d want=%0d", name, obs_v.size(), exp_v.size());
    end else begin
      for (int i = 0; i < exp_v.size(); i++) begin
        ntests++;
        if (obs_v[i] != exp_v[i] || obs_e[i] != exp_e[i]) begin
          nfail++;
          $display("FAIL %s step%0d got=%h@%0d want=%h@%0d",
                   name, i, obs_v[i], obs_e[i], exp_v[i], exp_e[i]);
        end
      end
    end
    ntests++;
    if (strobe_bad != 0) begin
      nfail++;
      $display("FAIL %s strobe_alignment got=%0d bad samples want=0", name, strobe_bad);
    end
    ntests++;
    if (dac_code !== 16'(tgt) || at_target !== 1'b1 || busy !== 1'b0 || target_ready !== 1'b1) begin
      nfail++;
      $display("FAIL %s final code=%h at=%b busy=%b ready=%b want code=%h at=1 busy=0 ready=1",
               name, dac_code, at_target, busy, target_ready, 16'(tgt));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      ntests++;
      if (target_ready !== 1'b0) begin
        nfail++;
        $display("FAIL reset_ready_low got=%b want=0", target_ready);
      end
    end
    rst = 1'b0;
    #1;
    mdl_code = 32'h8000;
    ntests++;
    if (dac_code !== 16'h8000 || at_target !== 1'b1 || busy !== 1'b0 ||
        update_strobe !== 1'b0 || target_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_state code=%h at=%b busy=%b strobe=%b ready=%b want 8000 1 0 0 1",
               dac_code, at_target, busy, update_strobe, target_ready);
    end
  endtask

  task automatic test_directed();
    do_ramp(32'h8010, 4, 1'b1, "ramp_up");
    do_ramp(32'h8000, 0, 1'b0, "byp_8000a");
    do_ramp(32'h800A, 4, 1'b1, "partial");
    do_ramp(32'h800A, 4, 1'b1, "same_target");
    do_ramp(32'h0003, 0, 1'b0, "byp_0003");
    do_ramp(32'h0000, 16, 1'b1, "no_wrap_bot");
    do_ramp(32'hFFFC, 0, 1'b0, "byp_fffc");
    do_ramp(32'hFFFF, 16, 1'b1, "no_wrap_top");
    do_ramp(32'h8000, 0, 1'b0, "byp_8000b");
    do_ramp(32'h8002, 0, 1'b1, "step_zero");
    do_ramp(32'hFFFF, 0, 1'b0, "byp_ffff");
  endtask

  task automatic test_coincident();
    do_ramp(32'h8000, 0, 1'b0, "byp_coinc");
    for (int i = 0; i < DIV && (edge_cnt % DIV) != DIV - 1; i++) step_cycle();
    do_ramp(32'h8008, 4, 1'b1, "coincident");
  endtask

  task automatic test_handshake();
    int ka, t2, hit;
    int bad;
    do_ramp(32'h8000, 0, 1'b0, "byp_hs");
    target_code  = 16'h8008;
    step_size    = 16'd4;
    ramp_enable  = 1'b1;
    target_valid = 1'b1;
    step_cycle();
    ka = edge_cnt;
    t2 = ((ka / DIV) + 2) * DIV;
    target_code = 16'h1234;
    ramp_enable = 1'b0;
    bad = 0;
    hit = -1;
    for (int c = 0; c < 30; c++) begin
      if (busy === 1'b1 && target_ready !== 1'b0) bad++;
      if (dac_code === 16'h1234) begin
        hit = edge_cnt;
        break;
      end
      step_cycle();
    end
    target_valid = 1'b0;
    mdl_code = 32'h1234;
    ntests++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL hs_ready_in_ramp got=%0d cycles ready=1 while busy want=0", bad);
    end
    ntests++;
    if (hit != t2 + 1) begin
      nfail++;
      $display("FAIL hs_accept_edge got=%0d want=%0d", hit, t2 + 1);
    end
    step_cycle();
  endtask

  task automatic test_reset_mid_ramp();
    int ka, t1;
    do_ramp(32'h8000, 0, 1'b0, "byp_rst");
    target_code  = 16'h9000;
    step_size    = 16'h0010;
    ramp_enable  = 1'b1;
    target_valid = 1'b1;
    step_cycle();
    target_valid = 1'b0;
    ka = edge_cnt;
    t1 = ((ka / DIV) + 1) * DIV;
    for (int c = 0; c < 2 * DIV && edge_cnt < t1 + DIV - 1; c++) step_cycle();
    ntests++;
    if (dac_code !== 16'h8010 || busy !== 1'b1) begin
      nfail++;
      $display("FAIL rst_mid_first_step code=%h busy=%b want 8010 1", dac_code, busy);
    end
    rst = 1'b1;
    step_cycle();
    ntests++;
    if (dac_code !== 16'h8000 || busy !== 1'b0 || at_target !== 1'b1 ||
        update_strobe !== 1'b0 || target_ready !== 1'b0) begin
      nfail++;
      $display("FAIL rst_mid_state code=%h busy=%b at=%b strobe=%b ready=%b want 8000 0 1 0 0",
               dac_code, busy, at_target, update_strobe, target_ready);
    end
    rst = 1'b0;
    #1;
    mdl_code = 32'h8000;
    step_cycle();
  endtask

  task automatic test_random();
    int s, span, tg;
    bit en;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) step_cycle();
      s    = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 40));
      en   = ($urandom_range(0, 3) != 0);
      span = ((s == 0) ? 1 : s) * int'($urandom_range(0, 6)) + int'($urandom_range(0, s));
      tg   = ($urandom_range(0, 1) == 1) ? mdl_code + span : mdl_code - span;
      if (i % 6 == 5) tg = ($urandom_range(0, 1) == 1) ? 0 : 65535;
      if (tg < 0) tg = 0;
      if (tg > 65535) tg = 65535;
      do_ramp(tg, s, en, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_coincident();
    test_handshake();
    test_reset_mid_ramp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
